// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width; never below one bit so WIDTH=2 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Gate-level full subtractor cell: d = x - y - bin with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign d       = x_xor_y ^ bin;
  assign bout    = (~x & y) | (~x_xor_y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done framing.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             done_q;
  logic             d_bit;
  logic             br_d;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // DONE accepts start like IDLE so operations can run back-to-back.
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          sa_q   <= sa_q >> 1;
          sb_q   <= sb_q >> 1;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start2 = 1'b0, bin2 = 1'b0, busy2, done2, bout2;
  logic [1:0] a2 = '0, b2 = '0, diff2;

  int unsigned sel = 8;
  logic        cur_busy, cur_done, cur_bout;
  logic [31:0] cur_diff;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always_comb begin
    cur_busy = busy8;
    cur_done = done8;
    cur_bout = bout8;
    cur_diff = {24'd0, diff8};
    if (sel == 2) begin
      cur_busy = busy2;
      cur_done = done2;
      cur_bout = bout2;
      cur_diff = {30'd0, diff2};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic s, input logic [31:0] av, input logic [31:0] bv, input logic bi);
    if (sel == 2) begin
      start2 = s; a2 = av[1:0]; b2 = bv[1:0]; bin2 = bi;
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
    end
  endtask

  // Entered at the first SHIFT cycle; counts busy cycles until done, bounded.
  task automatic wait_done(input int poke_at, output int unsigned nb);
    int unsigned lim;
    nb  = 0;
    lim = 0;
    while (!cur_done && lim < sel + 4) begin
      if (cur_busy) nb++;
      if (int'(lim) == poke_at) drv(1'b1, 32'd0, 32'd0, 1'b0);
      else drv(1'b0, $urandom, $urandom, 1'($urandom));
      lim++;
      @(negedge clk);
    end
    drv(1'b0, 32'd0, 32'd0, 1'b0);
    check("done_seen", {31'd0, cur_done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] av, input logic [31:0] bv,
                              input logic bi);
    longint      t;
    logic [31:0] mask;
    mask = (32'd1 << sel) - 32'd1;
    t    = longint'(av & mask) - longint'(bv & mask) - longint'(bi);
    check({tag, "_diff"}, cur_diff, 32'(t) & mask);
    check({tag, "_bout"}, {31'd0, cur_bout}, {31'd0, t < 0});
  endtask

  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    @(negedge clk);
    drv(1'b1, av, bv, bi);
    @(negedge clk);
    drv(1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic run_op(input string tag, input int unsigned w, input logic [31:0] av,
                        input logic [31:0] bv, input logic bi, input int poke_at);
    int unsigned nb;
    sel = w;
    launch(av, bv, bi);
    wait_done(poke_at, nb);
    check({tag, "_busy_cycles"}, nb, w);
    check({tag, "_busy_in_done"}, {31'd0, cur_busy}, 32'd0);
    check_result(tag, av, bv, bi);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, cur_done}, 32'd0);
    check({tag, "_hold"}, cur_diff, ((32'(longint'(av & ((32'd1 << w) - 1)) -
          longint'(bv & ((32'd1 << w) - 1)) - longint'(bi)))) & ((32'd1 << w) - 1));
  endtask

  initial begin
    int unsigned nb;
    int unsigned seen;

    #2;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_bout", {31'd0, bout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d100_37", 8, 100, 37, 1'b0, -1);
    run_op("d5_10",   8, 5,   10, 1'b0, -1);
    run_op("d0_0_b1", 8, 0,   0,  1'b1, -1);
    run_op("d255_255",8, 255, 255,1'b0, -1);
    run_op("ignore",  8, 200, 1,  1'b0, 3);

    // Back-to-back: start held in the DONE cycle begins the next op at once.
    sel = 8;
    launch(100, 37, 1'b0);
    wait_done(-1, nb);
    check_result("b2b_first", 100, 37, 1'b0);
    drv(1'b1, 9, 3, 1'b0);
    @(negedge clk);
    check("b2b_no_idle", {31'd0, busy8}, 32'd1);
    check("b2b_done_low", {31'd0, done8}, 32'd0);
    wait_done(-1, nb);
    check("b2b_busy_cycles", nb, 32'd8);
    check_result("b2b_second", 9, 3, 1'b0);

    // Reset during the 4th SHIFT cycle.
    launch(200, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy8}, 32'd0);
    check("mid_rst_done", {31'd0, done8}, 32'd0);
    check("mid_rst_diff", {24'd0, diff8}, 32'd0);
    check("mid_rst_bout", {31'd0, bout8}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check("mid_rst_quiet", seen, 32'd0);
    run_op("d17_17", 8, 17, 17, 1'b0, -1);

    for (int i = 0; i < 500; i++)
      run_op("rnd8", 8, $urandom, $urandom, 1'($urandom), -1);
    for (int i = 0; i < 500; i++)
      run_op("rnd2", 2, $urandom, $urandom, 1'($urandom), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
